// File: rtl/arith_ssd_display.sv
// arith_ssd_display
// Registers two unsigned WIDTH-bit operands, adds or subtracts them, converts
// the WIDTH+1-bit result to BCD with a free-running sequential double-dabble
// FSM, and scans the value onto a DIGITS-wide common-anode display
// (active-low anodes and segments) with leading-zero blanking.
//
// Optional feature macro: ARITH_SSD_NEG_EN
//   defined   : A-B with A<B shows magnitude B-A with a minus on the leftmost digit
//   undefined : A-B wraps modulo 2^(WIDTH+1), leftmost digit always blank
//
// state  | meaning
// S_IDLE | one-cycle gap between conversions, busy low
// S_LOAD | capture operands, compute result and sign, clear BCD scratch
// S_SHIFT| WIDTH+1 double-dabble iterations (adjust nibbles, shift left)
// S_DONE | publish BCD result and sign to the display register
module arith_ssd_display #(
  parameter int WIDTH         = 8,
  parameter int DIGITS        = 4,
  parameter int PRESCALE_BITS = 17
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  A,
  input  logic [WIDTH-1:0]  B,
  input  logic              sub,
  output logic              busy,
  output logic              valid,
  output logic [DIGITS-1:0] Anode,
  output logic [6:0]        LED_OUT
);

  localparam int RW = WIDTH + 1;
  localparam int BW = 4 * (DIGITS - 1);
  localparam int CW = ($clog2(WIDTH + 1) > 0) ? $clog2(WIDTH + 1) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b1111110;

  function automatic longint pow10(input int n);
    longint p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  localparam longint DEC_CAP = pow10(DIGITS - 1);
  localparam longint BIN_MAX = (longint'(1) << RW) - 1;

  // The value digits (all but the sign position) must hold the largest result.
  generate
    if (DEC_CAP <= BIN_MAX) begin : g_cfg_check
      $error("arith_ssd_display: DIGITS too small for WIDTH+1-bit result plus sign digit");
    end
  endgenerate

  // Hex to active-low {a,b,c,d,e,f,g}.
  function automatic logic [6:0] hex_seg(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'ha: s = 7'b0001000;
      4'hb: s = 7'b1100000;
      4'hc: s = 7'b0110001;
      4'hd: s = 7'b1000010;
      4'he: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state;

  logic [RW-1:0] bin;
  logic [BW-1:0] bcd;
  logic [BW-1:0] bcd_adj;
  logic [CW-1:0] bit_cnt;
  logic          neg;
  logic [BW-1:0] disp_bcd;
  logic          disp_neg;

  logic [RW-1:0] load_val;
  logic          load_neg;

  logic [PRESCALE_BITS-1:0] presc;
  logic [IW-1:0]            idx;
  logic [6:0]               digit_seg [DIGITS];
  logic [3:0]               nib;
  logic                     nonzero_above;

  // Operand arithmetic feeding the LOAD capture.
  always_comb begin
    load_neg = 1'b0;
    if (sub) load_val = {1'b0, A} - {1'b0, B};
    else     load_val = {1'b0, A} + {1'b0, B};
`ifdef ARITH_SSD_NEG_EN
    if (sub && (A < B)) begin
      load_val = {1'b0, B} - {1'b0, A};
      load_neg = 1'b1;
    end
`endif
  end

  // Double-dabble correction: every nibble of 5 or more gets +3 before the shift.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < DIGITS - 1; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // Conversion FSM with registered busy/valid and the display register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      valid    <= 1'b0;
      bin      <= '0;
      bcd      <= '0;
      bit_cnt  <= '0;
      neg      <= 1'b0;
      disp_bcd <= '0;
      disp_neg <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          busy  <= 1'b1;
          state <= S_LOAD;
        end
        S_LOAD: begin
          bin     <= load_val;
          neg     <= load_neg;
          bcd     <= '0;
          bit_cnt <= CW'(WIDTH);
          state   <= S_SHIFT;
        end
        S_SHIFT: begin
          {bcd, bin} <= {bcd_adj, bin} << 1;
          if (bit_cnt == '0) state <= S_DONE;
          else               bit_cnt <= bit_cnt - 1'b1;
        end
        S_DONE: begin
          disp_bcd <= bcd;
          disp_neg <= neg;
          valid    <= 1'b1;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Per-digit segment patterns with leading-zero blanking; digit 0 is never blanked.
  always_comb begin
    for (int i = 0; i < DIGITS; i++) digit_seg[i] = SEG_BLANK;
    nonzero_above = 1'b0;
    nib           = 4'd0;
    for (int i = DIGITS - 2; i >= 0; i--) begin
      nib           = disp_bcd[4*i +: 4];
      nonzero_above = nonzero_above | (nib != 4'd0);
      if (nonzero_above || (i == 0)) digit_seg[i] = hex_seg(nib);
    end
    digit_seg[DIGITS-1] = disp_neg ? SEG_MINUS : SEG_BLANK;
  end

  // Refresh prescaler; the digit index steps on each wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      idx   <= '0;
    end else begin
      presc <= presc + 1'b1;
      if (presc == '1) begin
        if (idx == IW'(DIGITS - 1)) idx <= '0;
        else                        idx <= idx + 1'b1;
      end
    end
  end

  // Registered display drive, so no combinational path from the operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Anode   <= '1;
      LED_OUT <= SEG_BLANK;
    end else begin
      Anode   <= ~(DIGITS'(1) << idx);
      LED_OUT <= digit_seg[idx];
    end
  end

endmodule

// File: tb/tb_arith_ssd_display.sv
// Scoreboard bench for arith_ssd_display (WIDTH=8, DIGITS=4, fast refresh).
module tb_arith_ssd_display;

  localparam int WIDTH  = 8;
  localparam int DIGITS = 4;
  localparam int PB     = 2;
  localparam int PERIOD = WIDTH + 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] a_in, b_in;
  logic       sub_in;
  logic       busy, valid;
  logic [3:0] anode;
  logic [6:0] led;

  int checks   = 0;
  int failures = 0;

  logic [27:0] exp_q [$];
  bit          mon_active = 1'b0;

  always #5 clk = ~clk;

  arith_ssd_display #(.WIDTH(WIDTH), .DIGITS(DIGITS), .PRESCALE_BITS(PB)) dut (
    .clk(clk), .rst_n(rst_n), .A(a_in), .B(b_in), .sub(sub_in),
    .busy(busy), .valid(valid), .Anode(anode), .LED_OUT(led)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, expv, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      default: return 7'b0000100;
    endcase
  endfunction

  // Expected four digit patterns {d3,d2,d1,d0} from plain decimal arithmetic.
  function automatic logic [27:0] model(input int a, input int b, input int s);
    int v;
    int pw;
    bit n;
    logic [27:0] r;
    n = 1'b0;
    if (s == 0)      v = a + b;
    else if (a >= b) v = a - b;
    else begin
`ifdef ARITH_SSD_NEG_EN
      v = b - a;
      n = 1'b1;
`else
      v = a - b + (1 << (WIDTH + 1));
`endif
    end
    r[27:21] = n ? 7'b1111110 : 7'b1111111;
    pw = 1;
    for (int i = 0; i < 3; i++) begin
      r[7*i +: 7] = (i > 0 && v < pw) ? 7'b1111111 : seg_of((v / pw) % 10);
      pw = pw * 10;
    end
    return r;
  endfunction

  // Monitor: per expected entry, follow one conversion, then scan all digits.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        logic [27:0] e;
        logic [6:0]  seen [4];
        int          n;
        int          hi;
        int          zeros;
        int          pos;
        bit          bad;
        mon_active = 1'b1;
        e = exp_q[0];
        for (int i = 0; i < 4; i++) seen[i] = 7'bxxxxxxx;
        n = 0;
        while (!busy && n < 50) begin
          @(negedge clk);
          n++;
        end
        if (!busy) begin
          check("busy_rise_timeout", {31'd0, busy}, 32'd1);
        end else begin
          hi = 0;
          n  = 0;
          while (busy && n < 50) begin
            hi++;
            @(negedge clk);
            n++;
          end
          check("busy_len", hi, 32'd11);
          check("valid_after_done", {31'd0, valid}, 32'd1);
          @(negedge clk);
          bad = 1'b0;
          for (int k = 0; k < 4 * (1 << PB); k++) begin
            zeros = 0;
            pos   = 0;
            for (int j = 0; j < 4; j++) if (anode[j] == 1'b0) begin
              zeros++;
              pos = j;
            end
            if (zeros != 1) bad = 1'b1;
            else            seen[pos] = led;
            @(negedge clk);
          end
          check("anode_onehot", {31'd0, bad}, 32'd0);
          for (int i = 0; i < 4; i++)
            check($sformatf("digit%0d", i), {25'd0, seen[i]}, {25'd0, e[7*i +: 7]});
        end
        void'(exp_q.pop_front());
        mon_active = 1'b0;
      end
    end
  end

  task automatic wait_mon();
    int n;
    n = 0;
    while ((exp_q.size() > 0 || mon_active) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("mon_drain", {31'd0, (exp_q.size() > 0 || mon_active)}, 32'd0);
  endtask

  task automatic sync_idle();
    int n;
    @(negedge clk);
    n = 0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("idle_sync", {31'd0, busy}, 32'd0);
  endtask

  task automatic apply(input int a, input int b, input int s);
    wait_mon();
    sync_idle();
    a_in   = 8'(a);
    b_in   = 8'(b);
    sub_in = s[0];
    exp_q.push_back(model(a, b, s));
    repeat (3 * PERIOD) @(negedge clk);
  endtask

  task automatic release_and_track();
    logic [3:0] ea;
    rst_n = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      ea = ~(4'd1 << (((k - 1) / 4) % 4));
      check("anode_seq", {28'd0, anode}, {28'd0, ea});
      if (k == PERIOD - 1) check("valid_pre_done", {31'd0, valid}, 32'd0);
      if (k == PERIOD)     check("valid_at_done", {31'd0, valid}, 32'd1);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_anode"}, {28'd0, anode}, 32'hF);
    check({tag, "_led"},   {25'd0, led},   32'h7F);
    check({tag, "_busy"},  {31'd0, busy},  32'd0);
    check({tag, "_valid"}, {31'd0, valid}, 32'd0);
  endtask

  initial begin
    rst_n  = 1'b0;
    a_in   = 8'd0;
    b_in   = 8'd0;
    sub_in = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("rst");
    exp_q.push_back(model(0, 0, 0));
    release_and_track();

    apply(255, 255, 0);
    apply(200, 57, 1);
    apply(3, 5, 1);
    apply(0, 255, 1);
    apply(9, 1, 0);
    for (int i = 0; i < 12; i++)
      apply(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 1)));

    // Abort a conversion in its fifth SHIFT cycle.
    wait_mon();
    sync_idle();
    a_in   = 8'd99;
    b_in   = 8'd1;
    sub_in = 1'b0;
    repeat (6) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_values("mid_rst");
    @(negedge clk);
    @(negedge clk);
    exp_q.push_back(model(99, 1, 0));
    release_and_track();

    wait_mon();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/arith_ssd_display.md
# arith_ssd_display

Parametrised add/subtract and seven-segment display engine for board-level lab tops. It registers two WIDTH-bit operands and computes their sum or difference. A sequential double-dabble FSM converts the result to BCD, and the block drives a DIGITS-wide multiplexed common-anode display with leading-zero blanking. It replaces the fixed 8-bit adder plus 4-digit display pairing with a single configurable block.

## Interface
- WIDTH, 8: operand width; the result is WIDTH+1 bits.
- DIGITS, 4: number of display digits; must satisfy 10^(DIGITS-1) > 2^(WIDTH+1)-1, which reserves the leftmost digit for the sign. This is checked by an elaboration-time assertion.
- PRESCALE_BITS, 17: digit-refresh prescaler width; the digit index advances on each prescaler wrap.
- clk  in  1  system clock (100 MHz board clock).
- rst_n  in  1  reset, asynchronous assert, active-low.
- A  in  WIDTH  operand A, unsigned.
- B  in  WIDTH  operand B, unsigned.
- sub  in  1  0: A+B; 1: A−B.
- busy  out  1  conversion in progress.
- valid  out  1  high once the first conversion has completed since reset; stays high until the next reset.
- Anode  out  DIGITS  digit enables, active-low; bit 0 is the rightmost digit.
- LED_OUT  out  7  segments {a,b,c,d,e,f,g}, active-low.

## Operation
- The FSM states are IDLE → LOAD → SHIFT → DONE → IDLE. The FSM restarts immediately, so conversions are free-running.
- IDLE: lasts one cycle; busy=0.
- LOAD: captures A, B and sub.
  - result = A+B, zero-extended to WIDTH+1 bits, or A−B computed in WIDTH+1 bits.
  - neg = sub & (A<B).
  - Clears the BCD scratch register (4·(DIGITS−1) bits).
  - Sets busy=1.
- SHIFT: runs exactly WIDTH+1 cycles, counted by the bit counter.
  - Each cycle, every BCD nibble ≥5 first gets +3.
  - Then the combined {bcd, bin} register shifts left by 1.
- DONE: copies the BCD result and neg into the display register. busy drops in the following IDLE.
- Display path, independent of the FSM:
  - The prescaler counts 0..2^PRESCALE_BITS−1.
  - On each wrap, the digit index increments modulo DIGITS, wrapping DIGITS−1 → 0.
  - Exactly one Anode bit is low: Anode = ~(1<<index).
- Digit content:
  - Leftmost digit (DIGITS−1) is the sign position: minus (7'b1111110) when the displayed value is negative, otherwise blank (7'b1111111).
  - Other digits show the hex-to-7-segment decode of their nibble.
  - Leading zeros are blanked. Digit 0 always shows its value, so a result of 0 displays a single "0".
- Operand changes during SHIFT have no effect until the next LOAD.

## Timing
- Conversion period: 1 (IDLE) + 1 (LOAD) + (WIDTH+1) (SHIFT) + 1 (DONE) = WIDTH+4 cycles. With WIDTH=8 this is 12 cycles.
- Input-to-display latency is at most 2·(WIDTH+4) cycles.
- The display register updates only on the DONE clock edge and is stable between DONE cycles.
- Reset values:
  - FSM in IDLE.
  - busy=0, valid=0.
  - Display register all zeros, neg=0.
  - Prescaler and index = 0.
  - Anode = all ones.
  - LED_OUT = 7'b1111111.
- Anode and LED_OUT are registered, with no combinational path from A, B or sub.
- Reset asserted mid-SHIFT aborts the conversion immediately. The display register is cleared, and after release the first DONE occurs WIDTH+4 cycles later.

## Configuration
- ARITH_SSD_NEG_EN defined:
  - For A<B with sub=1, result is the magnitude B−A and neg=1.
  - The minus sign appears on the leftmost digit.
- ARITH_SSD_NEG_EN undefined:
  - neg is tied to 0.
  - A−B wraps modulo 2^(WIDTH+1) and is displayed unsigned. For example, 3−5 with WIDTH=8 displays 510.
  - The leftmost digit is always blank.

## Test plan
- Reset, then release with A=0, B=0, sub=0 → Anode=4'b1111 and valid=0 during reset; after 12 cycles valid=1 and the display shows "0" on digit 0 only.
- A=255, B=255, sub=0 → after conversion the display shows 510, busy is high for exactly 11 cycles per conversion, and digit 3 is blank.
- A=200, B=57, sub=1 → displays 143 with no sign.
- A=3, B=5, sub=1 → with ARITH_SSD_NEG_EN: "-  2", sign on digit 3, digits 2 and 1 blank; without it: 510.
- PRESCALE_BITS=2 → Anode sequence 1110, 1101, 1011, 0111, 1110, …, each held 4 cycles, with exactly one bit low at a time.
- Assert rst_n during the 5th SHIFT cycle of A=99+B=1 → outputs return to reset values asynchronously; after release the display shows 100 at the first DONE.
